pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/apu_pkg.sv | 38 +++
 rtl/apu_envelope.sv | 44 ++++
 rtl/pulse_gen.sv | 166 ++++++++++++++++
 tb/tb_pulse_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the APU tone channels: register map, length table, duty patterns.
package apu_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_SWEEP = 2'd1;
  localparam logic [1:0] ADDR_PLO   = 2'd2;
  localparam logic [1:0] ADDR_PHI   = 2'd3;

  localparam logic [3:0] ENV_MAX = 4'd15;

  function automatic logic [7:0] length_lut(input logic [4:0] idx);
    logic [7:0] len;
    case (idx)
      5'd0:  len = 8'd10;  5'd1:  len = 8'd254; 5'd2:  len = 8'd20;  5'd3:  len = 8'd2;
      5'd4:  len = 8'd40;  5'd5:  len = 8'd4;   5'd6:  len = 8'd80;  5'd7:  len = 8'd6;
      5'd8:  len = 8'd160; 5'd9:  len = 8'd8;   5'd10: len = 8'd60;  5'd11: len = 8'd10;
      5'd12: len = 8'd14;  5'd13: len = 8'd12;  5'd14: len = 8'd26;  5'd15: len = 8'd14;
      5'd16: len = 8'd12;  5'd17: len = 8'd16;  5'd18: len = 8'd24;  5'd19: len = 8'd18;
      5'd20: len = 8'd48;  5'd21: len = 8'd20;  5'd22: len = 8'd96;  5'd23: len = 8'd22;
      5'd24: len = 8'd192; 5'd25: len = 8'd24;  5'd26: len = 8'd72;  5'd27: len = 8'd26;
      5'd28: len = 8'd16;  5'd29: len = 8'd28;  5'd30: len = 8'd32;  default: len = 8'd30;
    endcase
    return len;
  endfunction

  // One bit per sequencer index; index 0 is bit 0.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] idx);
    logic [7:0] pat;
    case (duty)
      2'd0:    pat = 8'b0000_0010;
      2'd1:    pat = 8'b0000_0110;
      2'd2:    pat = 8'b0001_1110;
      default: pat = 8'b1111_1001;
    endcase
    return pat[idx];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: decays 15..0 at the quarter-frame rate divided by vol+1, optional loop.
module apu_envelope
  import apu_pkg::*;
(
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic [3:0] vol_i,
  input  logic       loop_i,
  output logic [3:0] decay_o
);

  logic       start_q;
  logic [3:0] decay_q;
  logic [3:0] div_q;

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      decay_q <= '0;
      div_q   <= '0;
    end else begin
      if (tick_i) begin
        if (start_q) begin
          start_q <= 1'b0;
          decay_q <= ENV_MAX;
          div_q   <= vol_i;
        end else if (div_q == '0) begin
          div_q <= vol_i;
          if (decay_q != '0) decay_q <= decay_q - 4'd1;
          else if (loop_i)   decay_q <= ENV_MAX;
        end else begin
          div_q <= div_q - 4'd1;
        end
      end
      // A new note must restart the envelope even if it lands on a tick.
      if (start_i) start_q <= 1'b1;
    end
  end

  assign decay_o = decay_q;

endmodule

// File: rtl/pulse_gen.sv
// Square-wave tone channel: period timer, duty sequencer, length counter, sweep and envelope.
module pulse_gen
  import apu_pkg::*;
#(
  parameter int TIMER_W   = 11,
  parameter int ONES_COMP = 0
) (
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       tick_qtr,
  input  logic       tick_hlf,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       enable,
  output logic [3:0] pulse_out,
  output logic       active
);

  logic [1:0]         duty_q, duty_d;
  logic               halt_q, halt_d;
  logic               const_q, const_d;
  logic [3:0]         vol_q, vol_d;
  logic               sw_en_q, sw_en_d;
  logic [2:0]         sw_p_q, sw_p_d;
  logic               sw_neg_q, sw_neg_d;
  logic [2:0]         sw_sh_q, sw_sh_d;
  logic               sw_reload_q, sw_reload_d;
  logic [2:0]         sw_div_q, sw_div_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         seq_q, seq_d;
  logic [7:0]         len_q, len_d;
  logic [3:0]         pulse_q, pulse_d;

  logic [TIMER_W-1:0] change;
  logic [TIMER_W:0]   target;
  logic               mute;
  logic               env_start;
  logic [3:0]         decay;

  // The extra -1 models the first channel's ones'-complement negate.
  localparam logic [TIMER_W:0] NEG_BIAS = {{TIMER_W{1'b0}}, (ONES_COMP != 0)};

  assign change    = period_q >> sw_sh_q;
  assign target    = sw_neg_q ? ({1'b0, period_q} - {1'b0, change} - NEG_BIAS)
                              : ({1'b0, period_q} + {1'b0, change});
  assign mute      = (period_q[TIMER_W-1:3] == '0) || (!sw_neg_q && target[TIMER_W]);
  assign env_start = wr_en && (wr_addr == ADDR_PHI);

  apu_envelope u_env (
    .apu_clk (apu_clk),
    .rst_n   (rst_n),
    .tick_i  (tick_qtr),
    .start_i (env_start),
    .vol_i   (vol_q),
    .loop_i  (halt_q),
    .decay_o (decay)
  );

  always_comb begin
    duty_d      = duty_q;
    halt_d      = halt_q;
    const_d     = const_q;
    vol_d       = vol_q;
    sw_en_d     = sw_en_q;
    sw_p_d      = sw_p_q;
    sw_neg_d    = sw_neg_q;
    sw_sh_d     = sw_sh_q;
    sw_reload_d = sw_reload_q;
    sw_div_d    = sw_div_q;
    period_d    = period_q;
    seq_d       = seq_q;
    len_d       = len_q;

    if (timer_q == '0) begin
      timer_d = period_q;
      seq_d   = seq_q - 3'd1;
    end else begin
      timer_d = timer_q - TIMER_W'(1);
    end

    if (tick_hlf) begin
      if (!halt_q && len_q != '0) len_d = len_q - 8'd1;
      if (sw_div_q == '0 && sw_en_q && sw_sh_q != '0 && !mute)
        period_d = target[TIMER_W-1:0];
      if (sw_div_q == '0 || sw_reload_q) begin
        sw_div_d    = sw_p_q;
        sw_reload_d = 1'b0;
      end else begin
        sw_div_d = sw_div_q - 3'd1;
      end
    end

    // Register writes come last so they win over same-cycle frame updates.
    if (wr_en) begin
      case (wr_addr)
        ADDR_CTRL: begin
          duty_d  = wr_data[7:6];
          halt_d  = wr_data[5];
          const_d = wr_data[4];
          vol_d   = wr_data[3:0];
        end
        ADDR_SWEEP: begin
          sw_en_d     = wr_data[7];
          sw_p_d      = wr_data[6:4];
          sw_neg_d    = wr_data[3];
          sw_sh_d     = wr_data[2:0];
          sw_reload_d = 1'b1;
        end
        ADDR_PLO: period_d = {period_q[TIMER_W-1:8], wr_data};
        default: begin
          period_d = {wr_data[TIMER_W-9:0], period_q[7:0]};
          seq_d    = 3'd0;
          if (enable) len_d = length_lut(wr_data[7:3]);
        end
      endcase
    end

    if (!enable) len_d = '0;

    if (mute || len_q == '0 || !duty_bit(duty_q, seq_q)) pulse_d = 4'd0;
    else if (const_q)                                     pulse_d = vol_q;
    else                                                  pulse_d = decay;
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q      <= '0;
      halt_q      <= 1'b0;
      const_q     <= 1'b0;
      vol_q       <= '0;
      sw_en_q     <= 1'b0;
      sw_p_q      <= '0;
      sw_neg_q    <= 1'b0;
      sw_sh_q     <= '0;
      sw_reload_q <= 1'b0;
      sw_div_q    <= '0;
      period_q    <= '0;
      timer_q     <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      pulse_q     <= '0;
    end else begin
      duty_q      <= duty_d;
      halt_q      <= halt_d;
      const_q     <= const_d;
      vol_q       <= vol_d;
      sw_en_q     <= sw_en_d;
      sw_p_q      <= sw_p_d;
      sw_neg_q    <= sw_neg_d;
      sw_sh_q     <= sw_sh_d;
      sw_reload_q <= sw_reload_d;
      sw_div_q    <= sw_div_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      seq_q       <= seq_d;
      len_q       <= len_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;
  assign active    = (len_q != '0);

endmodule

// File: tb/tb_pulse_gen.sv
// Randomized bench for pulse_gen: two instances (plain and ones'-complement negate) against a behavioural model.
module tb_pulse_gen;

  localparam int TW = 11;

  typedef struct {
    int duty, halt, cnst, vol;
    int sw_en, sw_p, sw_neg, sw_sh;
    int period, timer, seq, len;
    int env_start, decay, env_div;
    int sw_div, sw_reload;
    int pout;
  } mdl_t;

  int LEN_TBL [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  int DUTY_PAT [4] = '{8'h02, 8'h06, 8'h1E, 8'hF9};

  logic       apu_clk;
  logic       rst_n;
  logic       tick_qtr, tick_hlf, wr_en, enable;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pulse_out0, pulse_out1;
  logic       active0, active1;

  int   n_chk = 0;
  int   n_bad = 0;
  mdl_t mdl [2];

  pulse_gen #(.TIMER_W(TW), .ONES_COMP(0)) u_dut0 (
    .apu_clk(apu_clk), .rst_n(rst_n), .tick_qtr(tick_qtr), .tick_hlf(tick_hlf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .enable(enable),
    .pulse_out(pulse_out0), .active(active0));

  pulse_gen #(.TIMER_W(TW), .ONES_COMP(1)) u_dut1 (
    .apu_clk(apu_clk), .rst_n(rst_n), .tick_qtr(tick_qtr), .tick_hlf(tick_hlf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .enable(enable),
    .pulse_out(pulse_out1), .active(active1));

  initial apu_clk = 1'b0;
  always #5 apu_clk = ~apu_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t z = '{default: 0};
    return z;
  endfunction

  function automatic int mdl_target(mdl_t m, int oc);
    int chg = m.period >> m.sw_sh;
    return m.sw_neg != 0 ? m.period - chg - oc : m.period + chg;
  endfunction

  function automatic bit mdl_mute(mdl_t m, int oc);
    return (m.period < 8) || (m.sw_neg == 0 && mdl_target(m, oc) >= (1 << TW));
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int oc, bit tq, bit th, bit we,
                                    bit [1:0] wa, bit [7:0] wd, bit en);
    mdl_t n = m;
    bit   mute = mdl_mute(m, oc);
    bit   on   = ((DUTY_PAT[m.duty] >> m.seq) & 1) != 0;
    n.pout = (mute || m.len == 0 || !on) ? 0 : (m.cnst != 0 ? m.vol : m.decay);
    if (m.timer == 0) begin
      n.timer = m.period;
      n.seq   = (m.seq + 7) % 8;
    end else n.timer = m.timer - 1;
    if (tq) begin
      if (m.env_start != 0) begin
        n.env_start = 0; n.decay = 15; n.env_div = m.vol;
      end else if (m.env_div == 0) begin
        n.env_div = m.vol;
        if (m.decay > 0) n.decay = m.decay - 1;
        else if (m.halt != 0) n.decay = 15;
      end else n.env_div = m.env_div - 1;
    end
    if (th) begin
      if (m.halt == 0 && m.len > 0) n.len = m.len - 1;
      if (m.sw_div == 0 && m.sw_en != 0 && m.sw_sh != 0 && !mute)
        n.period = mdl_target(m, oc) & ((1 << TW) - 1);
      if (m.sw_div == 0 || m.sw_reload != 0) begin
        n.sw_div = m.sw_p; n.sw_reload = 0;
      end else n.sw_div = m.sw_div - 1;
    end
    if (we) begin
      case (wa)
        2'd0: begin n.duty = wd >> 6; n.halt = wd[5]; n.cnst = wd[4]; n.vol = wd & 15; end
        2'd1: begin n.sw_en = wd[7]; n.sw_p = (wd >> 4) & 7; n.sw_neg = wd[3];
                    n.sw_sh = wd & 7; n.sw_reload = 1; end
        2'd2: n.period = (m.period & ~255) | wd;
        default: begin
          n.period = (m.period & 255) | ((wd & 7) << 8);
          n.seq = 0; n.env_start = 1;
          if (en) n.len = LEN_TBL[wd >> 3];
        end
      endcase
    end
    if (!en) n.len = 0;
    return n;
  endfunction

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cycle(input bit tq, input bit th, input bit we, input bit [1:0] wa,
                       input bit [7:0] wd, input bit en);
    tick_qtr = tq; tick_hlf = th; wr_en = we; wr_addr = wa; wr_data = wd; enable = en;
    for (int k = 0; k < 2; k++) mdl[k] = mdl_step(mdl[k], k, tq, th, we, wa, wd, en);
    @(posedge apu_clk);
    @(negedge apu_clk);
    tick_qtr = 1'b0; tick_hlf = 1'b0; wr_en = 1'b0;
    chk("pout0", int'(pulse_out0), mdl[0].pout);
    chk("pout1", int'(pulse_out1), mdl[1].pout);
    chk("active0", int'(active0), int'(mdl[0].len != 0));
    chk("active1", int'(active1), int'(mdl[1].len != 0));
    chk("period0", int'(u_dut0.period_q), mdl[0].period);
    chk("period1", int'(u_dut1.period_q), mdl[1].period);
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, enable);
  endtask

  // Asserts reset between edges and checks that outputs drop without a clock.
  task automatic arst();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pout0", int'(pulse_out0), 0);
    chk("arst_active0", int'(active0), 0);
    chk("arst_pout1", int'(pulse_out1), 0);
    chk("arst_active1", int'(active1), 0);
    for (int k = 0; k < 2; k++) mdl[k] = mdl_reset();
    @(negedge apu_clk);
    rst_n = 1'b1;
  endtask

  bit       r_tq, r_th, r_we, r_en;
  bit [1:0] r_wa;
  bit [7:0] r_wd;

  initial begin
    rst_n = 1'b0; tick_qtr = 1'b0; tick_hlf = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 8'd0; enable = 1'b1;
    for (int k = 0; k < 2; k++) mdl[k] = mdl_reset();
    repeat (3) @(negedge apu_clk);
    chk("rst_pout", int'(pulse_out0), 0);
    chk("rst_active", int'(active0), 0);
    chk("rst_period", int'(u_dut0.period_q), 0);
    rst_n = 1'b1;

    // 50% duty, constant volume 15, 17 clocks per step
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h08);
    idle(150);
    chk("duty_active", int'(active0), 1);

    // envelope decay with loop off
    arst();
    wr(2'd0, 8'h03); wr(2'd2, 8'h20); wr(2'd3, 8'h08);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
      idle(3);
    end
    idle(40);

    // length index 3 runs out after two half-frames
    arst();
    wr(2'd0, 8'h10); wr(2'd2, 8'h20); wr(2'd3, 8'h18);
    idle(5);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1); idle(3);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("len_expired", int'(active0), 0);
    chk("len_pout", int'(pulse_out0), 0);
    wr(2'd3, 8'h08);
    chk("len_reload", int'(active0), 1);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    chk("enable_off", int'(active0), 0);
    enable = 1'b1;

    // sweep up, then sweep overflow mutes
    arst();
    wr(2'd0, 8'hBF); wr(2'd2, 8'h00); wr(2'd3, 8'h04); wr(2'd1, 8'h81);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("sweep_up", int'(u_dut0.period_q), 'h600);
    arst();
    wr(2'd0, 8'hBF); wr(2'd2, 8'hF0); wr(2'd3, 8'h07); wr(2'd1, 8'h81);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("sweep_mute_period", int'(u_dut0.period_q), 'h7F0);
    idle(40);
    chk("sweep_mute_pout", int'(pulse_out0), 0);

    // negate: twos' vs ones' complement
    arst();
    wr(2'd1, 8'h89); wr(2'd2, 8'h00); wr(2'd3, 8'h01);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
    chk("neg_twos", int'(u_dut0.period_q), 'h080);
    chk("neg_ones", int'(u_dut1.period_q), 'h07F);

    // reset mid-note stays silent until reg 3 rewritten
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h08);
    idle(30);
    arst();
    wr(2'd0, 8'hBF); wr(2'd2, 8'h10);
    idle(60);
    chk("silent_after_rst", int'(active0), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) arst();
      r_tq = ($urandom_range(0, 5) == 0);
      r_th = r_tq && ($urandom_range(0, 1) == 1);
      r_we = ($urandom_range(0, 9) == 0);
      r_wa = 2'($urandom_range(0, 3));
      r_wd = 8'($urandom_range(0, 255));
      if (r_wa == 2'd3 && $urandom_range(0, 3) != 0) r_wd[2:0] = 3'd0;
      r_en = ($urandom_range(0, 49) != 0);
      cycle(r_tq, r_th, r_we, r_wa, r_wd, r_en);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
